// File: rtl/id_ex_stage_register_pkg.sv
// Shared constants for the ID/EX pipeline register.
// Condition codes, ALU commands and the bubble control bundle.
package id_ex_stage_register_pkg;

   localparam logic [3:0] COND_EQ = 4'b0000;
   localparam logic [3:0] COND_NE = 4'b0001;
   localparam logic [3:0] COND_CS = 4'b0010;
   localparam logic [3:0] COND_CC = 4'b0011;
   localparam logic [3:0] COND_MI = 4'b0100;
   localparam logic [3:0] COND_PL = 4'b0101;
   localparam logic [3:0] COND_VS = 4'b0110;
   localparam logic [3:0] COND_VC = 4'b0111;
   localparam logic [3:0] COND_HI = 4'b1000;
   localparam logic [3:0] COND_LS = 4'b1001;
   localparam logic [3:0] COND_GE = 4'b1010;
   localparam logic [3:0] COND_LT = 4'b1011;
   localparam logic [3:0] COND_GT = 4'b1100;
   localparam logic [3:0] COND_LE = 4'b1101;
   localparam logic [3:0] COND_AL = 4'b1110;

   localparam logic [3:0] EXE_NOP = 4'b0000;
   localparam logic [3:0] EXE_MOV = 4'b0001;
   localparam logic [3:0] EXE_ADD = 4'b0010;
   localparam logic [3:0] EXE_ADC = 4'b0011;
   localparam logic [3:0] EXE_SUB = 4'b0100;
   localparam logic [3:0] EXE_SBC = 4'b0101;
   localparam logic [3:0] EXE_AND = 4'b0110;
   localparam logic [3:0] EXE_ORR = 4'b0111;
   localparam logic [3:0] EXE_EOR = 4'b1000;
   localparam logic [3:0] EXE_MVN = 4'b1001;

   typedef struct packed {
      logic       wb_en;
      logic       mem_r;
      logic       mem_w;
      logic       b;
      logic       s;
      logic [3:0] exe_cmd;
   } ctrl_t;

   localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/id_ex_stage_register_if.sv
// ID-to-EX bundle: ID-side inputs and EX-side registered outputs.
// master drives the ID fields, slave is the pipeline register.
interface id_ex_stage_register_if #(
   parameter int DATA_WIDTH     = 32,
   parameter int REG_ADDR_WIDTH = 4,
   parameter int CNT_WIDTH      = 16
) ();
   logic                      FREEZE;
   logic                      FLUSH;
   logic                      ID_VALID;
   logic                      COND_PASS;
   logic [3:0]                COND_IN;
   logic                      WB_EN_IN;
   logic                      MEM_R_IN;
   logic                      MEM_W_IN;
   logic                      B_IN;
   logic                      S_IN;
   logic [3:0]                EXE_CMD_IN;
   logic [DATA_WIDTH-1:0]     PC_IN;
   logic [DATA_WIDTH-1:0]     VAL_RN_IN;
   logic [DATA_WIDTH-1:0]     VAL_RM_IN;
   logic [11:0]               SHIFT_OPERAND_IN;
   logic                      IMM_IN;
   logic [23:0]               SIGNED_IMM_24_IN;
   logic [REG_ADDR_WIDTH-1:0] DEST_IN;
   logic [REG_ADDR_WIDTH-1:0] SRC1_IN;
   logic [REG_ADDR_WIDTH-1:0] SRC2_IN;
   logic [3:0]                STATUS_IN;

   logic                      WB_EN_OUT;
   logic                      MEM_R_OUT;
   logic                      MEM_W_OUT;
   logic                      B_OUT;
   logic                      S_OUT;
   logic [3:0]                EXE_CMD_OUT;
   logic [DATA_WIDTH-1:0]     PC_OUT;
   logic [DATA_WIDTH-1:0]     VAL_RN_OUT;
   logic [DATA_WIDTH-1:0]     VAL_RM_OUT;
   logic [11:0]               SHIFT_OPERAND_OUT;
   logic                      IMM_OUT;
   logic [23:0]               SIGNED_IMM_24_OUT;
   logic [REG_ADDR_WIDTH-1:0] DEST_OUT;
   logic [REG_ADDR_WIDTH-1:0] SRC1_OUT;
   logic [REG_ADDR_WIDTH-1:0] SRC2_OUT;
   logic [3:0]                STATUS_OUT;
   logic                      EX_VALID;
   logic                      FLAG_HAZARD;
   logic [CNT_WIDTH-1:0]      SQUASH_CNT;

   modport master (
      output FREEZE, FLUSH, ID_VALID, COND_PASS, COND_IN,
      output WB_EN_IN, MEM_R_IN, MEM_W_IN, B_IN, S_IN,
      output EXE_CMD_IN, PC_IN, VAL_RN_IN, VAL_RM_IN,
      output SHIFT_OPERAND_IN, IMM_IN, SIGNED_IMM_24_IN,
      output DEST_IN, SRC1_IN, SRC2_IN, STATUS_IN,
      input  WB_EN_OUT, MEM_R_OUT, MEM_W_OUT, B_OUT, S_OUT,
      input  EXE_CMD_OUT, PC_OUT, VAL_RN_OUT, VAL_RM_OUT,
      input  SHIFT_OPERAND_OUT, IMM_OUT, SIGNED_IMM_24_OUT,
      input  DEST_OUT, SRC1_OUT, SRC2_OUT, STATUS_OUT,
      input  EX_VALID, FLAG_HAZARD, SQUASH_CNT
   );

   modport slave (
      input  FREEZE, FLUSH, ID_VALID, COND_PASS, COND_IN,
      input  WB_EN_IN, MEM_R_IN, MEM_W_IN, B_IN, S_IN,
      input  EXE_CMD_IN, PC_IN, VAL_RN_IN, VAL_RM_IN,
      input  SHIFT_OPERAND_IN, IMM_IN, SIGNED_IMM_24_IN,
      input  DEST_IN, SRC1_IN, SRC2_IN, STATUS_IN,
      output WB_EN_OUT, MEM_R_OUT, MEM_W_OUT, B_OUT, S_OUT,
      output EXE_CMD_OUT, PC_OUT, VAL_RN_OUT, VAL_RM_OUT,
      output SHIFT_OPERAND_OUT, IMM_OUT, SIGNED_IMM_24_OUT,
      output DEST_OUT, SRC1_OUT, SRC2_OUT, STATUS_OUT,
      output EX_VALID, FLAG_HAZARD, SQUASH_CNT
   );
endinterface

// File: rtl/id_ex_stage_register_cond_squash_counter.sv
// Saturating event counter for condition-squashed instructions.
// Sticks at all-ones instead of wrapping.
module cond_squash_counter #(
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 en,
   output logic [CNT_WIDTH-1:0] cnt
);
   logic [CNT_WIDTH-1:0] cnt_q;
   logic [CNT_WIDTH-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (en && (cnt_q != '1))
         cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign cnt = cnt_q;
endmodule

// File: rtl/id_ex_stage_register.sv
// ID/EX pipeline register with condition squash and flag hazard.
// Define ID_EX_PERF_CNT_EN to add the saturating squash counter.
module id_ex_stage_register
   import id_ex_stage_register_pkg::*;
#(
   parameter int DATA_WIDTH     = 32,
   parameter int REG_ADDR_WIDTH = 4,
   parameter int CNT_WIDTH      = 16
) (
   input logic                  CLK,
   input logic                  RST_N,
   id_ex_stage_register_if.slave bus
);
   typedef struct packed {
      logic [DATA_WIDTH-1:0]     pc;
      logic [DATA_WIDTH-1:0]     rn;
      logic [DATA_WIDTH-1:0]     rm;
      logic [11:0]               shift;
      logic                      imm;
      logic [23:0]               simm;
      logic [REG_ADDR_WIDTH-1:0] dest;
      logic [REG_ADDR_WIDTH-1:0] src1;
      logic [REG_ADDR_WIDTH-1:0] src2;
      logic [3:0]                status;
   } dp_t;

   ctrl_t ctrl_in, ctrl_d, ctrl_q;
   dp_t   dp_in, dp_d, dp_q;
   logic  valid_d, valid_q;

   assign ctrl_in = '{wb_en:   bus.WB_EN_IN,
                      mem_r:   bus.MEM_R_IN,
                      mem_w:   bus.MEM_W_IN,
                      b:       bus.B_IN,
                      s:       bus.S_IN,
                      exe_cmd: bus.EXE_CMD_IN};

   assign dp_in = '{pc:     bus.PC_IN,
                    rn:     bus.VAL_RN_IN,
                    rm:     bus.VAL_RM_IN,
                    shift:  bus.SHIFT_OPERAND_IN,
                    imm:    bus.IMM_IN,
                    simm:   bus.SIGNED_IMM_24_IN,
                    dest:   bus.DEST_IN,
                    src1:   bus.SRC1_IN,
                    src2:   bus.SRC2_IN,
                    status: bus.STATUS_IN};

   always_comb begin
      valid_d = valid_q;
      ctrl_d  = ctrl_q;
      dp_d    = dp_q;
      if (bus.FLUSH || (!bus.FREEZE && !bus.ID_VALID)) begin
         valid_d = 1'b0;
         ctrl_d  = CTRL_BUBBLE;
         dp_d    = '0;
      end else if (!bus.FREEZE) begin
         // A failed condition keeps operands but kills all side effects.
         dp_d    = dp_in;
         valid_d = bus.COND_PASS;
         ctrl_d  = bus.COND_PASS ? ctrl_in : CTRL_BUBBLE;
      end
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         valid_q <= 1'b0;
         ctrl_q  <= CTRL_BUBBLE;
         dp_q    <= '0;
      end else begin
         valid_q <= valid_d;
         ctrl_q  <= ctrl_d;
         dp_q    <= dp_d;
      end
   end

   assign bus.EX_VALID          = valid_q;
   assign bus.WB_EN_OUT         = ctrl_q.wb_en;
   assign bus.MEM_R_OUT         = ctrl_q.mem_r;
   assign bus.MEM_W_OUT         = ctrl_q.mem_w;
   assign bus.B_OUT             = ctrl_q.b;
   assign bus.S_OUT             = ctrl_q.s;
   assign bus.EXE_CMD_OUT       = ctrl_q.exe_cmd;
   assign bus.PC_OUT            = dp_q.pc;
   assign bus.VAL_RN_OUT        = dp_q.rn;
   assign bus.VAL_RM_OUT        = dp_q.rm;
   assign bus.SHIFT_OPERAND_OUT = dp_q.shift;
   assign bus.IMM_OUT           = dp_q.imm;
   assign bus.SIGNED_IMM_24_OUT = dp_q.simm;
   assign bus.DEST_OUT          = dp_q.dest;
   assign bus.SRC1_OUT          = dp_q.src1;
   assign bus.SRC2_OUT          = dp_q.src2;
   assign bus.STATUS_OUT        = dp_q.status;

   // Flags from a conditional ID check would predate this S-instruction.
   assign bus.FLAG_HAZARD = valid_q & ctrl_q.s & bus.ID_VALID
                          & (bus.COND_IN != COND_AL);

`ifdef ID_EX_PERF_CNT_EN
   logic squash_en;

   assign squash_en = ~bus.FLUSH & ~bus.FREEZE
                    & bus.ID_VALID & ~bus.COND_PASS;

   cond_squash_counter #(
      .CNT_WIDTH (CNT_WIDTH)
   ) u_cnt (
      .clk   (CLK),
      .rst_n (RST_N),
      .en    (squash_en),
      .cnt   (bus.SQUASH_CNT)
   );
`else
   assign bus.SQUASH_CNT = {CNT_WIDTH{1'b0}};
`endif
endmodule

// File: tb/tb_id_ex_stage_register.sv
// Directed table-driven bench for id_ex_stage_register.
// Squash-count expectations follow ID_EX_PERF_CNT_EN.
module tb_id_ex_stage_register;
   import id_ex_stage_register_pkg::*;

   localparam int DW = 32;
   localparam int RW = 4;
   localparam int CW = 2;

   logic clk;
   logic rst_n;
   int   checks;
   int   failures;

   id_ex_stage_register_if #(
      .DATA_WIDTH     (DW),
      .REG_ADDR_WIDTH (RW),
      .CNT_WIDTH      (CW)
   ) bus ();

   id_ex_stage_register #(
      .DATA_WIDTH     (DW),
      .REG_ADDR_WIDTH (RW),
      .CNT_WIDTH      (CW)
   ) dut (
      .CLK   (clk),
      .RST_N (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        fz, fl, iv, cp;
      logic        wb, mr, s;
      logic [3:0]  cmd;
      logic [3:0]  dest;
      logic [31:0] pc;
      logic        e_v, e_wb, e_mr, e_s;
      logic [3:0]  e_cmd;
      logic [3:0]  e_dest;
      logic [31:0] e_pc;
      int          e_cnt;
   } vec_t;

   vec_t vecs[7];

   function automatic int ce(input int x);
`ifdef ID_EX_PERF_CNT_EN
      return x;
`else
      return 0 * x;
`endif
   endfunction

   task automatic check(input string nm,
                        input logic [63:0] act,
                        input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic zero_inputs();
      bus.FREEZE = 0; bus.FLUSH = 0;
      bus.ID_VALID = 0; bus.COND_PASS = 0;
      bus.COND_IN = COND_AL;
      bus.WB_EN_IN = 0; bus.MEM_R_IN = 0;
      bus.MEM_W_IN = 0; bus.B_IN = 0; bus.S_IN = 0;
      bus.EXE_CMD_IN = 0; bus.PC_IN = 0;
      bus.VAL_RN_IN = 0; bus.VAL_RM_IN = 0;
      bus.SHIFT_OPERAND_IN = 0; bus.IMM_IN = 0;
      bus.SIGNED_IMM_24_IN = 0;
      bus.DEST_IN = 0; bus.SRC1_IN = 0; bus.SRC2_IN = 0;
      bus.STATUS_IN = 0;
   endtask

   task automatic nonzero_inputs();
      bus.ID_VALID = 1; bus.COND_PASS = 1;
      bus.COND_IN = COND_NE;
      bus.WB_EN_IN = 1; bus.MEM_R_IN = 1;
      bus.MEM_W_IN = 1; bus.B_IN = 1; bus.S_IN = 1;
      bus.EXE_CMD_IN = 4'hA; bus.PC_IN = 32'h1234_5678;
      bus.VAL_RN_IN = 32'hCAFE_0001;
      bus.VAL_RM_IN = 32'hBEEF_0002;
      bus.SHIFT_OPERAND_IN = 12'hABC; bus.IMM_IN = 1;
      bus.SIGNED_IMM_24_IN = 24'h80_0001;
      bus.DEST_IN = 4'hD; bus.SRC1_IN = 4'h1;
      bus.SRC2_IN = 4'h2; bus.STATUS_IN = 4'hF;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_ex_valid"}, 64'(bus.EX_VALID), 0);
      check({tag, "_ctrl"}, 64'({bus.WB_EN_OUT, bus.MEM_R_OUT,
            bus.MEM_W_OUT, bus.B_OUT, bus.S_OUT}), 0);
      check({tag, "_cmd"}, 64'(bus.EXE_CMD_OUT), 0);
      check({tag, "_pc"}, 64'(bus.PC_OUT), 0);
      check({tag, "_rn_rm"}, {bus.VAL_RN_OUT, bus.VAL_RM_OUT}, 0);
      check({tag, "_imm"}, 64'({bus.SHIFT_OPERAND_OUT, bus.IMM_OUT,
            bus.SIGNED_IMM_24_OUT}), 0);
      check({tag, "_regs"}, 64'({bus.DEST_OUT, bus.SRC1_OUT,
            bus.SRC2_OUT, bus.STATUS_OUT}), 0);
      check({tag, "_cnt"}, 64'(bus.SQUASH_CNT), 0);
   endtask

   initial begin
      checks = 0;
      failures = 0;
      rst_n = 0;
      zero_inputs();

      // fz fl iv cp wb mr s cmd dest pc | v wb mr s cmd dest pc cnt
      vecs[0] = '{0,0,1,1, 1,0,0, 4'h2,4'h5,32'h100,
                  1,1,0,0, 4'h2,4'h5,32'h100, 0};
      vecs[1] = '{0,0,1,0, 1,0,0, 4'h2,4'h5,32'h104,
                  0,0,0,0, 4'h0,4'h5,32'h104, 1};
      vecs[2] = '{0,0,1,1, 0,1,1, 4'h4,4'h3,32'h108,
                  1,0,1,1, 4'h4,4'h3,32'h108, 1};
      vecs[3] = '{1,0,1,0, 1,1,1, 4'h9,4'h9,32'h200,
                  1,0,1,1, 4'h4,4'h3,32'h108, 1};
      vecs[4] = '{1,1,1,0, 1,1,1, 4'h9,4'h9,32'h200,
                  0,0,0,0, 4'h0,4'h0,32'h0, 1};
      vecs[5] = '{0,0,1,1, 1,0,0, 4'hF,4'hF,32'hFFFF_FFFC,
                  1,1,0,0, 4'hF,4'hF,32'hFFFF_FFFC, 1};
      vecs[6] = '{0,0,0,0, 1,1,1, 4'h7,4'h6,32'h300,
                  0,0,0,0, 4'h0,4'h0,32'h0, 1};

      tick();
      tick();
      check_all_zero("reset");
      rst_n = 1;

      foreach (vecs[i]) begin
         bus.FREEZE = vecs[i].fz;
         bus.FLUSH = vecs[i].fl;
         bus.ID_VALID = vecs[i].iv;
         bus.COND_PASS = vecs[i].cp;
         bus.WB_EN_IN = vecs[i].wb;
         bus.MEM_R_IN = vecs[i].mr;
         bus.S_IN = vecs[i].s;
         bus.EXE_CMD_IN = vecs[i].cmd;
         bus.DEST_IN = vecs[i].dest;
         bus.PC_IN = vecs[i].pc;
         tick();
         check($sformatf("v%0d_valid", i),
               64'(bus.EX_VALID), 64'(vecs[i].e_v));
         check($sformatf("v%0d_ctrl", i),
               64'({bus.WB_EN_OUT, bus.MEM_R_OUT, bus.S_OUT}),
               64'({vecs[i].e_wb, vecs[i].e_mr, vecs[i].e_s}));
         check($sformatf("v%0d_cmd", i),
               64'(bus.EXE_CMD_OUT), 64'(vecs[i].e_cmd));
         check($sformatf("v%0d_dest", i),
               64'(bus.DEST_OUT), 64'(vecs[i].e_dest));
         check($sformatf("v%0d_pc", i),
               64'(bus.PC_OUT), 64'(vecs[i].e_pc));
         check($sformatf("v%0d_cnt", i),
               64'(bus.SQUASH_CNT), 64'(ce(vecs[i].e_cnt)));
      end

      // freeze holds for three cycles while ID inputs change
      zero_inputs();
      bus.ID_VALID = 1; bus.COND_PASS = 1;
      bus.WB_EN_IN = 1; bus.EXE_CMD_IN = EXE_ADC;
      bus.DEST_IN = 4'h7; bus.PC_IN = 32'h400;
      bus.VAL_RN_IN = 32'hDEAD;
      tick();
      for (int k = 0; k < 3; k++) begin
         bus.FREEZE = 1;
         bus.PC_IN = 32'h500 + 32'(k);
         bus.DEST_IN = 4'(k);
         bus.VAL_RN_IN = 32'(k);
         bus.COND_PASS = 1'(k);
         tick();
         check($sformatf("frz%0d_valid", k), 64'(bus.EX_VALID), 1);
         check($sformatf("frz%0d_data", k),
               {bus.PC_OUT, bus.VAL_RN_OUT}, {32'h400, 32'hDEAD});
         check($sformatf("frz%0d_dest", k), 64'(bus.DEST_OUT), 7);
         check($sformatf("frz%0d_cnt", k),
               64'(bus.SQUASH_CNT), 64'(ce(1)));
      end

      // flag hazard against a valid S=1 instruction in EX
      zero_inputs();
      bus.ID_VALID = 1; bus.COND_PASS = 1; bus.S_IN = 1;
      bus.EXE_CMD_IN = EXE_SUB;
      tick();
      bus.S_IN = 0;
      bus.COND_IN = COND_EQ;
      #1;
      check("hz_eq", 64'(bus.FLAG_HAZARD), 1);
      bus.COND_IN = COND_AL;
      #1;
      check("hz_al", 64'(bus.FLAG_HAZARD), 0);
      bus.COND_IN = COND_EQ; bus.ID_VALID = 0;
      #1;
      check("hz_idinv", 64'(bus.FLAG_HAZARD), 0);
      bus.ID_VALID = 1; bus.S_IN = 1; bus.COND_PASS = 0;
      tick();
      check("hz_squashed_s", 64'(bus.FLAG_HAZARD), 0);

      // saturation from a fresh reset
      zero_inputs();
      rst_n = 0;
      tick();
      rst_n = 1;
      check("sat_reset_cnt", 64'(bus.SQUASH_CNT), 0);
      bus.ID_VALID = 1; bus.COND_PASS = 0;
      bus.WB_EN_IN = 1; bus.DEST_IN = 4'h5;
      for (int k = 0; k < 5; k++) begin
         tick();
         check($sformatf("sat%0d_cnt", k), 64'(bus.SQUASH_CNT),
               64'(ce(k < 3 ? k + 1 : 3)));
         check($sformatf("sat%0d_valid", k),
               64'({bus.EX_VALID, bus.WB_EN_OUT, bus.DEST_OUT}),
               64'({1'b0, 1'b0, 4'h5}));
      end

      // reset mid-stream overrides freeze
      zero_inputs();
      nonzero_inputs();
      tick();
      check("pre_rst_valid", 64'(bus.EX_VALID), 1);
      bus.FREEZE = 1;
      rst_n = 0;
      tick();
      check_all_zero("mid_rst");
      rst_n = 1;

      // reset also overrides flush+freeze
      bus.FREEZE = 0;
      tick();
      bus.FREEZE = 1; bus.FLUSH = 1;
      rst_n = 0;
      tick();
      check_all_zero("rst_flush");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/id_ex_stage_register.md
# id_ex_stage_register

Pipeline register between the ID stage and the EX stage of the ARM core. Captures decoded control and operand values each cycle and consumes the condition-check pass/fail bit: an instruction whose condition fails enters EX as a bubble. It also raises a flag hazard when a flag-setting instruction in EX would make the ID-stage condition check read stale NZCV. An optional saturating counter tracks condition-squashed instructions.

## Interface
- DATA_WIDTH, 32, operand/PC width
- REG_ADDR_WIDTH, 4, register index width
- CNT_WIDTH, 16, squash counter width (used only with ID_EX_PERF_CNT_EN)

- CLK  in  1  clock, all state updates on rising edge
- RST_N  in  1  reset; one clock, synchronous, active-low
- FREEZE  in  1  hold all contents (hazard stall)
- FLUSH  in  1  load a bubble (taken branch in EX)
- ID_VALID  in  1  ID holds a real instruction
- COND_PASS  in  1  condition-check result for the ID instruction
- COND_IN  in  4  ID instruction condition field
- WB_EN_IN, MEM_R_IN, MEM_W_IN, B_IN, S_IN  in  1 each  decoded control
- EXE_CMD_IN  in  4  ALU command
- PC_IN, VAL_RN_IN, VAL_RM_IN  in  DATA_WIDTH  PC+4 and register operands
- SHIFT_OPERAND_IN  in  12; IMM_IN  in  1; SIGNED_IMM_24_IN  in  24
- DEST_IN, SRC1_IN, SRC2_IN  in  REG_ADDR_WIDTH  register indices
- STATUS_IN  in  4  NZCV at ID (carry for ADC/SBC)
- Matching *_OUT registered outputs for every *_IN above except COND_IN
- EX_VALID  out  1  EX holds a real, condition-passed instruction
- FLAG_HAZARD  out  1  stall request to hazard unit
- SQUASH_CNT  out  CNT_WIDTH  condition-squash count (macro only)

## Operation
- Per-edge priority: RST_N low > FLUSH > FREEZE > load.
- Reset: all outputs 0, including EX_VALID, SQUASH_CNT.
- FLUSH: bubble — EX_VALID, WB_EN, MEM_R, MEM_W, B, S = 0; EXE_CMD = 0; datapath fields = 0. FLUSH with FREEZE: flush wins.
- FREEZE (no FLUSH): every register holds; counter holds.
- Load, ID_VALID=1, COND_PASS=1: capture all fields, EX_VALID=1.
- Load, ID_VALID=1, COND_PASS=0: condition squash — capture PC/datapath/index fields; force control bits and EX_VALID to 0.
- Load, ID_VALID=0: bubble as for FLUSH.
- FLAG_HAZARD = EX_VALID & S_OUT & (COND_IN != AL) & ID_VALID. It is combinational. Hazard unit must answer with FREEZE and hold ID for that cycle. The condition re-evaluates next cycle with committed flags.

## Timing
- All *_OUT, EX_VALID: one-cycle latency from ID inputs. They are registered with no combinational path from inputs.
- FLAG_HAZARD is the only combinational output. Path: COND_IN/ID_VALID and registered state. Valid in the same cycle.
- A squash in cycle n makes EX_VALID=0 in cycle n+1.
- Reset asserted mid-stream clears on the next edge and overrides FREEZE/FLUSH.

## Configuration
- ID_EX_PERF_CNT_EN defined: SQUASH_CNT counts edges with load-case ID_VALID=1, COND_PASS=0, not FLUSH or FREEZE. It saturates at all-ones (no wrap), resets to 0, and holds under FREEZE/FLUSH.
- Not defined: counter absent, SQUASH_CNT tied to 0, no extra flops.

## Structure
- Shared package holds:
  - condition-code constants EQ..AL (AL = 4'b1110);
  - EXE_CMD encodings;
  - the bubble control constant (all control zeros).
- Sub-module cond_squash_counter: saturating CNT_WIDTH counter with enable and sync active-low reset. Instantiated only under ID_EX_PERF_CNT_EN.

## Test plan
- RST_N=0 one edge with FREEZE=1, all inputs nonzero -> every output 0 next cycle.
- ID_VALID=1, COND_PASS=1, WB_EN_IN=1, EXE_CMD_IN=4'b0010, DEST_IN=5 -> next cycle EX_VALID=1, WB_EN_OUT=1, EXE_CMD_OUT=4'b0010, DEST_OUT=5.
- Same stimulus with COND_PASS=0 -> EX_VALID=0, WB_EN_OUT=0, DEST_OUT=5; SQUASH_CNT 0->1 (macro on).
- FREEZE=1 and FLUSH=1 together on a loaded stage -> bubble, EX_VALID=0; FREEZE alone for 3 cycles -> outputs unchanged.
- EX holds a valid S=1 instruction, ID has COND_IN=EQ, ID_VALID=1 -> FLAG_HAZARD=1 in the same cycle; COND_IN=AL -> FLAG_HAZARD=0.
- CNT_WIDTH=2, five consecutive squashes -> SQUASH_CNT sequence 1,2,3,3,3.
